joy_dir_filter: RTL and testbench

// - Parametrised multi-player joystick direction conditioner; successor to the single-player 4-way restrictor.
// - Per player: 2-flop sync, per-bit debounce, opposite-direction (SOCD) resolution, mode-selected restriction.
// - Modes: pass-through, 4-way last-press-wins, 4-way first-held-wins, horizontal-only.
// - Sits between keyboard/joystick merge and target_top p*_up/dw/lt/rt inputs in each arcade core top.

---
 rtl/joy_dir_filter_pkg.sv | 28 ++
 rtl/joy_dir_filter_if.sv | 14 +
 rtl/joy_dir_filter_chan.sv | 120 ++++++++++++
 rtl/joy_dir_filter.sv | 42 ++++
 tb/tb_joy_dir_filter.sv | 132 +++++++++++++
 5 files changed

// File: rtl/joy_dir_filter_pkg.sv
// Shared types and helpers for the joystick direction conditioner.
// Direction nibble packing is {up, down, left, right}.
package joy_pkg;

  typedef enum logic [1:0] {
    JM_PASS  = 2'b00,
    JM_LAST  = 2'b01,
    JM_FIRST = 2'b10,
    JM_HORZ  = 2'b11
  } joy_mode_t;

  localparam int DIR_UP = 3;
  localparam int DIR_DN = 2;
  localparam int DIR_LT = 1;
  localparam int DIR_RT = 0;

  // One-hot highest-priority set bit: up > down > left > right.
  function automatic logic [3:0] prio1(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if (v[DIR_UP])      r[DIR_UP] = 1'b1;
    else if (v[DIR_DN]) r[DIR_DN] = 1'b1;
    else if (v[DIR_LT]) r[DIR_LT] = 1'b1;
    else if (v[DIR_RT]) r[DIR_RT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/joy_dir_filter_if.sv
// Mode/direction bundle between the input merge and the conditioner.
interface joy_dir_filter_if #(
  parameter int NPLAYERS = 2
);
  import joy_pkg::*;

  joy_mode_t                   mode;
  logic [NPLAYERS-1:0][3:0]    indir;
  logic [NPLAYERS-1:0][3:0]    outdir;
  logic [NPLAYERS-1:0]         chg;

  modport master (output mode, output indir, input outdir, input chg);
  modport slave  (input mode, input indir, output outdir, output chg);
endinterface

// File: rtl/joy_dir_filter_chan.sv
// One player channel: 2-flop sync, per-bit debounce, SOCD resolve,
// mode-selected restriction mask and registered output with change pulse.
module joy_dir_chan
  import joy_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic      clk_sys,
  input  logic      reset,
  input  joy_mode_t mode,
  input  joy_mode_t mode_q,
  input  logic [3:0] raw,
  output logic [3:0] outdir,
  output logic       chg
);

  logic [3:0] s1, s2, deb;
  logic [3:0] s, s_q, new_p;
  logic [3:0] mask, mask_nx, out_nx;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1 <= 4'b0;
      s2 <= 4'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  generate
    if (DEB_CYCLES == 0) begin : g_nodeb
      assign deb = s2;
    end else begin : g_deb
      localparam int CW = $clog2(DEB_CYCLES + 1);
      logic [3:0][CW-1:0] cnt;
      logic [3:0]         deb_r;

      // Counter only runs while sync disagrees; it can never pass DEB_CYCLES-1.
      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          cnt   <= '0;
          deb_r <= 4'b0;
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (s2[b] == deb_r[b]) begin
              cnt[b] <= '0;
            end else if (cnt[b] == CW'(DEB_CYCLES - 1)) begin
              deb_r[b] <= s2[b];
              cnt[b]   <= '0;
            end else begin
              cnt[b] <= cnt[b] + 1'b1;
            end
          end
        end
      end
      assign deb = deb_r;
    end
  endgenerate

  // Opposing directions cancel before any mode logic sees them.
  always_comb begin
    s = deb;
    if (deb[DIR_UP] && deb[DIR_DN]) begin
      s[DIR_UP] = 1'b0;
      s[DIR_DN] = 1'b0;
    end
    if (deb[DIR_LT] && deb[DIR_RT]) begin
      s[DIR_LT] = 1'b0;
      s[DIR_RT] = 1'b0;
    end
  end

  assign new_p = s & ~s_q;

  always_comb begin
    mask_nx = mask;
    out_nx  = s;
    if (mode != mode_q) begin
      mask_nx = 4'b0;
    end else begin
      case (mode)
        JM_LAST: begin
          if (|new_p)
            mask_nx = prio1(new_p);
          else if (mask == 4'b0 || |(mask & ~s))
            mask_nx = prio1(s);
        end
        JM_FIRST: begin
          // Held direction wins; re-arbitrate only once it is gone.
          if (mask == 4'b0 || |(mask & ~s))
            mask_nx = prio1(s);
        end
        default: mask_nx = 4'b0;
      endcase
    end
    case (mode)
      JM_PASS:  out_nx = s;
      JM_LAST,
      JM_FIRST: out_nx = s & mask_nx;
      JM_HORZ:  out_nx = {2'b00, s[1:0]};
      default:  out_nx = s;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s_q    <= 4'b0;
      mask   <= 4'b0;
      outdir <= 4'b0;
      chg    <= 1'b0;
    end else begin
      s_q    <= s;
      mask   <= mask_nx;
      outdir <= out_nx;
      chg    <= (out_nx != outdir);
    end
  end

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction conditioner: one channel per player,
// sharing a registered copy of the mode to detect mode switches.
module joy_dir_filter
  import joy_pkg::*;
#(
  parameter int NPLAYERS   = 2,
  parameter int DEB_CYCLES = 16
) (
  input logic              clk_sys,
  input logic              reset,
  joy_dir_filter_if.slave  bus
);

  joy_mode_t                mode_q;
  logic [NPLAYERS-1:0][3:0] outdir_w;
  logic [NPLAYERS-1:0]      chg_w;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) mode_q <= JM_PASS;
    else       mode_q <= bus.mode;
  end

  generate
    for (genvar p = 0; p < NPLAYERS; p++) begin : g_chan
      joy_dir_chan #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_chan (
        .clk_sys (clk_sys),
        .reset   (reset),
        .mode    (bus.mode),
        .mode_q  (mode_q),
        .raw     (bus.indir[p]),
        .outdir  (outdir_w[p]),
        .chg     (chg_w[p])
      );
    end
  endgenerate

  assign bus.outdir = outdir_w;
  assign bus.chg    = chg_w;

endmodule

// File: tb/tb_joy_dir_filter.sv
// Directed bench for joy_dir_filter with NPLAYERS=2, DEB_CYCLES=4.
module tb_joy_dir_filter;
  import joy_pkg::*;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  joy_dir_filter_if #(.NPLAYERS(2)) bus ();

  joy_dir_filter #(.NPLAYERS(2), .DEB_CYCLES(4)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    joy_mode_t  mode;
    logic [7:0] indir;
    logic [7:0] exp_out;
  } vec_t;

  vec_t tbl [19];

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  initial begin
    bus.mode  = JM_PASS;
    bus.indir = '0;
    tick(3);
    chk("reset_out", bus.outdir, 8'h00);
    chk("reset_chg", {6'b0, bus.chg}, 8'h00);
    reset = 1'b0;
    tick(2);

    // Latency: step at cycle 0, visible after edge 7.
    bus.indir = 8'h01;
    tick(6);
    chk("lat_before", bus.outdir, 8'h00);
    tick(1);
    chk("lat_out", bus.outdir, 8'h01);
    chk("lat_chg", {6'b0, bus.chg}, 8'h01);
    tick(1);
    chk("lat_chg_off", {6'b0, bus.chg}, 8'h00);
    bus.indir = 8'h00;
    tick(10);
    chk("lat_release", bus.outdir, 8'h00);

    // Glitch of 3 cycles must never pass the debouncer.
    bus.indir = 8'h08;
    tick(3);
    bus.indir = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("glitch", {bus.outdir[0], 2'b00, bus.chg}, 8'h00);
    end

    tbl[0]  = '{JM_LAST,  8'h02, 8'h02};
    tbl[1]  = '{JM_LAST,  8'h0A, 8'h08};
    tbl[2]  = '{JM_LAST,  8'h02, 8'h02};
    tbl[3]  = '{JM_LAST,  8'h00, 8'h00};
    tbl[4]  = '{JM_FIRST, 8'h01, 8'h01};
    tbl[5]  = '{JM_FIRST, 8'h05, 8'h01};
    tbl[6]  = '{JM_FIRST, 8'h04, 8'h04};
    tbl[7]  = '{JM_FIRST, 8'h00, 8'h00};
    tbl[8]  = '{JM_PASS,  8'hB0, 8'h80};
    tbl[9]  = '{JM_HORZ,  8'hB0, 8'h00};
    tbl[10] = '{JM_HORZ,  8'hA0, 8'h20};
    tbl[11] = '{JM_PASS,  8'h00, 8'h00};
    tbl[12] = '{JM_LAST,  8'h09, 8'h08};
    tbl[13] = '{JM_LAST,  8'h00, 8'h00};
    tbl[14] = '{JM_PASS,  8'h5A, 8'h5A};
    tbl[15] = '{JM_PASS,  8'h3C, 8'h00};
    tbl[16] = '{JM_LAST,  8'h22, 8'h22};
    tbl[17] = '{JM_FIRST, 8'h22, 8'h22};
    tbl[18] = '{JM_FIRST, 8'h00, 8'h00};

    for (int i = 0; i < 19; i++) begin
      bus.mode  = tbl[i].mode;
      bus.indir = tbl[i].indir;
      tick(10);
      chk($sformatf("vec%0d_out", i), bus.outdir, tbl[i].exp_out);
      chk($sformatf("vec%0d_chg", i), {6'b0, bus.chg}, 8'h00);
    end

    // Reset mid-hold clears outputs asynchronously; held press reappears.
    bus.mode  = JM_PASS;
    bus.indir = 8'h04;
    tick(10);
    chk("rst_hold", bus.outdir, 8'h04);
    reset = 1'b1;
    #1;
    chk("rst_async_out", bus.outdir, 8'h00);
    chk("rst_async_chg", {6'b0, bus.chg}, 8'h00);
    tick(2);
    reset = 1'b0;
    tick(6);
    chk("rst_rel_before", bus.outdir, 8'h00);
    tick(1);
    chk("rst_rel_out", bus.outdir, 8'h04);
    chk("rst_rel_chg", {6'b0, bus.chg}, 8'h01);
    tick(1);
    chk("rst_rel_chg_off", {6'b0, bus.chg}, 8'h00);

    // Channel isolation: p0 holds right while p1 churns.
    bus.indir = 8'h01;
    tick(10);
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) bus.indir[1] = 4'(i / 6 + 5);
      tick(1);
      chk("isolate", {bus.outdir[0], 3'b000, bus.chg[0]}, 8'h10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
